prim_cmd_issuer: RTL and testbench
==================================

Name: prim_cmd_issuer

Overview:
- Command-side initiator for the primitive renderer.
- Buffers 16-bit renderer command words written by the host register interface in a FIFO, then issues them to the renderer's cmd/cmd_valid input at up to one word per cycle.
- Words with the execute opcode are held back until the renderer is no longer busy. After an execute is issued, issue stalls until that primitive completes, so coordinate, colour and destination registers are never overwritten mid-draw.

Parameters:
DEPTH, 16, FIFO depth in words (power of two, 2..64)
EXEC_OP, xv::PR_EXECUTE, 4-bit opcode in bits [15:12] that triggers rendering
EXEC_GUARD, 2, cycles after issuing an execute during which prim_busy_i is ignored (renderer start-to-busy latency)

Ports:
clk  input  1  clock
reset_i  input  1  synchronous active-high reset
wr_i  input  1  host write strobe, one word per cycle
data_i  input  16  host command word ([15:12] opcode, [11:0] operand)
flush_i  input  1  discard all queued words and clear overflow
full_o  output  1  FIFO holds DEPTH words
level_o  output  $clog2(DEPTH)+1  words currently queued
overflow_o  output  1  sticky: a write was dropped
cmd_o  output  16  command word to renderer
cmd_valid_o  output  1  cmd_o valid this cycle (single-cycle pulse per word)
prim_busy_i  input  1  renderer busy
idle_o  output  1  FIFO empty, state ISSUE, renderer not busy

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset_i).
- Reset: FIFO empty, level_o=0, full_o=0, overflow_o=0, cmd_valid_o=0, cmd_o=0, state ISSUE, guard counter 0. Reset mid-draw discards everything; the renderer is not signalled.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - A write is accepted when wr_i=1 and full_o=0. The full_o check uses the registered count, so a simultaneous pop does not admit a write to a full FIFO.
  - A write when full is dropped and sets overflow_o, which stays set until reset_i or flush_i.
  - Push and pop in the same cycle leave level_o unchanged.
  - Pointers wrap modulo DEPTH.
- Outputs cmd_o and cmd_valid_o are registered. A word popped at edge N appears on cmd_o with cmd_valid_o=1 during cycle N+1. The head is visible on cmd_o the cycle after pop.
- State machine:
  - ISSUE:
    - If the FIFO is non-empty and the head opcode != EXEC_OP, pop and present it.
    - If the head opcode == EXEC_OP and prim_busy_i=0, pop and present it, load the guard counter with EXEC_GUARD, and go to GUARD.
    - If the head is execute and prim_busy_i=1, hold with no pop.
    - If the FIFO is empty, cmd_valid_o=0.
  - GUARD: no pops. Decrement the counter each cycle; at 0 go to WAIT.
  - WAIT: no pops. When prim_busy_i=0, go to ISSUE. A pop may occur the same cycle only from the following ISSUE cycle, i.e. one cycle after busy is seen low.
- Non-execute words never wait on prim_busy_i while in ISSUE.
- cmd_valid_o is 0 in every cycle with no pop on the previous edge. It is never high for two cycles carrying the same word.
- flush_i:
  - Empties the FIFO, clears overflow_o, and sets level_o=0 next cycle.
  - A wr_i in the same cycle as flush_i is discarded.
  - State and guard counter are unaffected, so an in-flight execute still waits for busy to drop.
  - A word presented in the flush cycle, already popped, still appears on cmd_o.
- idle_o is combinational from the registered count, state and prim_busy_i.
- Throughput: back-to-back non-execute words issue at 1 word/clk. An execute costs at least EXEC_GUARD+1 cycles plus the draw time.

Test Plan:
- Reset, then write 0x0010, 0x1020, 0x2030 on consecutive cycles with prim_busy_i=0 -> cmd_valid_o high 3 consecutive cycles carrying the words in order; level_o returns to 0; idle_o=1.
- Queue X0..Y2, colour, then EXEC_OP word (8 words). Renderer model raises busy 2 cycles after the execute pulse and holds it 20 cycles. Queue 0x0005 after it -> 0x0005 issues only on the cycle after busy falls, never during GUARD/WAIT.
- prim_busy_i=1 with execute at the FIFO head -> no cmd_valid_o until busy drops. A non-execute head under the same busy=1 issues immediately.
- Write DEPTH+2 words with no pops (busy held, execute at head) -> full_o=1 after 16 writes, level_o=16, overflow_o=1, and the last 2 words are never issued.
- Full FIFO: assert wr_i and flush_i together -> level_o=0, overflow_o=0, no further cmd_valid_o. Then 0x3001 written -> issues normally.
- Assert reset_i during WAIT with 5 words queued -> next cycle cmd_valid_o=0, level_o=0, state ISSUE; a new write issues without waiting for prim_busy_i.

Source files
------------

// File: rtl/prim_cmd_issuer.sv
// Command FIFO between the host register interface and the primitive renderer.
// Execute words are held until the renderer is idle, then issue stalls until the draw finishes.
module prim_cmd_issuer #(
   parameter int         DEPTH      = 16,
   parameter logic [3:0] EXEC_OP    = 4'hF,
   parameter int         EXEC_GUARD = 2
) (
   input  logic                     clk,
   input  logic                     reset_i,
   input  logic                     wr_i,
   input  logic [15:0]              data_i,
   input  logic                     flush_i,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o,
   output logic [15:0]              cmd_o,
   output logic                     cmd_valid_o,
   input  logic                     prim_busy_i,
   output logic                     idle_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = (EXEC_GUARD > 1) ? $clog2(EXEC_GUARD + 1) : 1;
   localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
   localparam logic [GW-1:0] GUARD_LOAD = GW'(EXEC_GUARD);

   typedef enum logic [1:0] {ISSUE, GUARD, WAIT} state_t;

   state_t          state, state_d;
   logic [GW-1:0]   guard, guard_d;
   logic [15:0]     mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [AW:0]     count;
   logic [15:0]     head;
   logic            push, pop, empty, head_exec;

   assign empty     = (count == '0);
   assign full_o    = (count == FULL_CNT);
   assign level_o   = count;
   assign head      = mem[rd_ptr];
   assign head_exec = (head[15:12] == EXEC_OP);
   // Full is judged on the registered count, so a same-cycle pop never admits a write to a full FIFO.
   assign push      = wr_i && !full_o && !flush_i;
   assign idle_o    = empty && (state == ISSUE) && !prim_busy_i;

   always_comb begin
      state_d = state;
      guard_d = guard;
      pop     = 1'b0;
      unique case (state)
         ISSUE: begin
            if (!empty && !flush_i) begin
               if (!head_exec) begin
                  pop = 1'b1;
               end else if (!prim_busy_i) begin
                  pop     = 1'b1;
                  guard_d = GUARD_LOAD;
                  state_d = GUARD;
               end
            end
         end
         // Busy is ignored here: the renderer needs a few cycles to raise it after an execute.
         GUARD: begin
            if (guard > GW'(1)) begin
               guard_d = guard - 1'b1;
            end else begin
               guard_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!prim_busy_i) state_d = ISSUE;
         end
         default: state_d = ISSUE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state       <= ISSUE;
         guard       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         overflow_o  <= 1'b0;
         cmd_o       <= '0;
         cmd_valid_o <= 1'b0;
      end else begin
         state       <= state_d;
         guard       <= guard_d;
         cmd_valid_o <= pop;
         if (pop) cmd_o <= head;
         if (flush_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (wr_i && full_o) overflow_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_i;
   end

endmodule

// File: tb/tb_prim_cmd_issuer.sv
// Bench for prim_cmd_issuer: directed scenarios plus random traffic against a
// reference of issued order and a simple renderer model.
module tb_prim_cmd_issuer;

   localparam int         DEPTH = 16;
   localparam logic [3:0] EXEC  = 4'hF;

   logic                   clk;
   logic                   reset_i;
   logic                   wr_i;
   logic [15:0]            data_i;
   logic                   flush_i;
   logic                   full_o;
   logic [$clog2(DEPTH):0] level_o;
   logic                   overflow_o;
   logic [15:0]            cmd_o;
   logic                   cmd_valid_o;
   logic                   prim_busy_i;
   logic                   idle_o;

   prim_cmd_issuer #(.DEPTH(DEPTH), .EXEC_OP(EXEC), .EXEC_GUARD(2)) dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .wr_i        (wr_i),
      .data_i      (data_i),
      .flush_i     (flush_i),
      .full_o      (full_o),
      .level_o     (level_o),
      .overflow_o  (overflow_o),
      .cmd_o       (cmd_o),
      .cmd_valid_o (cmd_valid_o),
      .prim_busy_i (prim_busy_i),
      .idle_o      (idle_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   int ncyc = 0;
   int valid_cnt = 0;
   int run_len = 0;
   int last_valid_cyc = -10;
   int w5_cyc = -1;
   bit gate_open = 1'b1;
   int fall_cyc = -10;
   int rend_dly = 0;
   int rend_hold = 0;
   int hold_len = 20;
   bit rend_busy = 1'b0;
   bit busy_force = 1'b0;

   assign prim_busy_i = rend_busy | busy_force;

   logic [15:0] t2 [9] = '{16'h1010, 16'h2020, 16'h3030, 16'h4040, 16'h5050,
                           16'h6060, 16'h7007, 16'hF000, 16'h0005};

   // ---------------- monitor + renderer model ----------------
   // A word may only appear once the previous draw's busy has fallen, and not before
   // the second cycle after the fall.
   always @(negedge clk) begin
      logic [15:0] e;
      ncyc++;
      if (reset_i) gate_open = 1'b1;
      if (cmd_valid_o) begin
         valid_cnt++;
         run_len = (last_valid_cyc == ncyc - 1) ? run_len + 1 : 1;
         last_valid_cyc = ncyc;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_cmd: got %h, none expected", cmd_o);
         end else begin
            e = exp_q.pop_front();
            if (cmd_o !== e) begin
               bad++;
               $display("FAIL cmd_order: got %h expected %h", cmd_o, e);
            end
         end
         total++;
         if (!(gate_open && ncyc >= fall_cyc + 2)) begin
            bad++;
            $display("FAIL issue_during_draw: got %h at cycle %0d, draw ended cycle %0d", cmd_o, ncyc, fall_cyc);
         end
         if (cmd_o == 16'h0005) w5_cyc = ncyc;
      end
      if (rend_hold > 0) begin
         rend_hold--;
         if (rend_hold == 0) begin
            rend_busy = 1'b0;
            fall_cyc  = ncyc;
            gate_open = 1'b1;
         end
      end else if (rend_dly > 0) begin
         rend_dly--;
         if (rend_dly == 0) begin
            rend_busy = 1'b1;
            rend_hold = hold_len;
         end
      end
      if (cmd_valid_o && cmd_o[15:12] == EXEC) begin
         gate_open = 1'b0;
         rend_dly  = 2;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic write_word(input logic [15:0] w, input bit acc);
      wr_i   = 1'b1;
      data_i = w;
      if (acc) exp_q.push_back(w);
      @(posedge clk); #1;
      wr_i = 1'b0;
   endtask

   task automatic wait_valid(output int n, input int max);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (cmd_valid_o) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #1;
         if (idle_o && exp_q.size() == 0 && !rend_busy && rend_dly == 0) return;
      end
      total++;
      bad++;
      $display("FAIL wait_idle: got queue=%0d idle=%0b, expected drained and idle", exp_q.size(), idle_o);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int vc;
      logic [3:0] op;
      reset_i = 1'b1;
      wr_i    = 1'b0;
      data_i  = '0;
      flush_i = 1'b0;
      cycles(3);
      chk("reset_level", level_o, 0);
      chk("reset_full", full_o, 0);
      chk("reset_overflow", overflow_o, 0);
      chk("reset_valid", cmd_valid_o, 0);
      chk("reset_cmd", cmd_o, 0);
      chk("reset_idle", idle_o, 1);
      reset_i = 1'b0;
      cycles(2);

      // three plain words back to back
      write_word(16'h0010, 1'b1);
      write_word(16'h1020, 1'b1);
      write_word(16'h2030, 1'b1);
      wait_idle(50);
      chk("burst_run_len", run_len, 3);
      chk("burst_level", level_o, 0);
      chk("burst_idle", idle_o, 1);

      // full primitive with a trailing word behind the execute
      hold_len = 20;
      for (int i = 0; i < 9; i++) write_word(t2[i], 1'b1);
      wait_idle(200);
      chk("post_draw_issue_cycle", w5_cyc, fall_cyc + 2);

      // execute at head while busy, then plain word under busy
      hold_len = 6;
      busy_force = 1'b1;
      vc = valid_cnt;
      write_word(16'hF123, 1'b1);
      cycles(8);
      chk("exec_held_busy", valid_cnt - vc, 0);
      busy_force = 1'b0;
      wait_valid(n, 10);
      chk("exec_release_latency", n, 2);
      wait_idle(100);
      busy_force = 1'b1;
      write_word(16'h0042, 1'b1);
      wait_valid(n, 10);
      chk("plain_under_busy_latency", n, 2);
      busy_force = 1'b0;
      wait_idle(100);

      // fill past capacity, then flush with a concurrent write
      busy_force = 1'b1;
      write_word(16'hF000, 1'b1);
      for (int i = 1; i <= 17; i++) begin
         write_word(16'h0100 + 16'(i), i < 16);
         if (i == 15) begin
            chk("fill_full", full_o, 1);
            chk("fill_level", level_o, DEPTH);
            chk("fill_no_overflow", overflow_o, 0);
         end
      end
      chk("over_overflow", overflow_o, 1);
      chk("over_level", level_o, DEPTH);
      chk("over_full", full_o, 1);
      flush_i = 1'b1;
      wr_i    = 1'b1;
      data_i  = 16'hAAAA;
      @(posedge clk); #1;
      flush_i = 1'b0;
      wr_i    = 1'b0;
      exp_q.delete();
      chk("flush_level", level_o, 0);
      chk("flush_overflow", overflow_o, 0);
      chk("flush_full", full_o, 0);
      vc = valid_cnt;
      busy_force = 1'b0;
      cycles(10);
      chk("flush_no_issue", valid_cnt - vc, 0);
      write_word(16'h3001, 1'b1);
      wait_valid(n, 10);
      chk("after_flush_latency", n, 2);
      wait_idle(100);

      // reset while waiting on a draw with words queued
      hold_len = 20;
      write_word(16'hF0AA, 1'b1);
      n = 0;
      while (!rend_busy && n < 20) begin
         cycles(1);
         n++;
      end
      chk("draw_started", rend_busy, 1);
      for (int i = 1; i <= 5; i++) write_word(16'h0A00 + 16'(i), 1'b0);
      chk("wait_queued_level", level_o, 5);
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      exp_q.delete();
      chk("midreset_valid", cmd_valid_o, 0);
      chk("midreset_level", level_o, 0);
      write_word(16'h0077, 1'b1);
      wait_valid(n, 10);
      chk("midreset_issue_latency", n, 2);
      wait_idle(100);

      // random traffic
      for (int k = 0; k < 200; k++) begin
         cycles($urandom_range(0, 2));
         if (exp_q.size() < DEPTH) begin
            hold_len = $urandom_range(1, 8);
            op = ($urandom_range(0, 5) == 0) ? EXEC : 4'($urandom_range(0, 14));
            write_word({op, 12'($urandom)}, 1'b1);
         end else begin
            cycles(1);
         end
      end
      wait_idle(500);
      chk("random_level", level_o, 0);
      chk("random_overflow", overflow_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
